// File: rtl/mnist_nn_led_arbiter.sv
// mnist_nn_led_arbiter: shares the 14-bit LED drive between an Avalon SW pattern and NN results (optional LED_ARB_BLINK_EN)
module mnist_nn_led_arbiter #(
  parameter int TICK_DIV = 50000,
  parameter int HOLD_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [3:0]  res_digit,
  input  logic [6:0]  res_aux,
  output logic [13:0] out_port
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic {SW, HW} state_t;
  state_t state_q, state_d;
  logic [13:0] swdata_q, swdata_d, hw_pat_q, hw_pat_d, out_q, out_d;
  logic hw_en_q, hw_en_d, lock_q, lock_d, blink_q, blink_d, phase_q, phase_d;
  logic [HOLD_W-1:0] hold_q, hold_d, cnt_q, cnt_d;
  logic [3:0] last_q, last_d;
  logic [PW-1:0] pre_q, pre_d;
  logic wr, sw_wr, accept, tick, unused_ok;
  assign unused_ok = &{1'b0, writedata};
  assign res_ready = hw_en_q & ~lock_q;
  assign out_port  = out_q;
  assign readdata  = address == 2'd0 ? {18'b0, swdata_q} :
                     address == 2'd1 ? {28'b0, blink_q, 1'b0, lock_q, hw_en_q} :
                     address == 2'd2 ? {24'b0, last_q, 2'b0, res_valid, state_q == HW} :
                     32'(hold_q);
  // register writes, result capture, hold countdown and the display selection for the next cycle
  always_comb begin
    wr       = chipselect & ~write_n;
    sw_wr    = wr && address == 2'd0;
    accept   = res_valid & res_ready;
    tick     = pre_q == PW'(TICK_DIV - 1);
    swdata_d = sw_wr ? writedata[13:0] : swdata_q;
    hw_en_d  = wr && address == 2'd1 ? writedata[0] : hw_en_q;
    lock_d   = wr && address == 2'd1 ? writedata[1] : lock_q;
`ifdef LED_ARB_BLINK_EN
    blink_d  = wr && address == 2'd1 ? writedata[3] : blink_q;
`else
    blink_d  = 1'b0;
`endif
    hold_d   = wr && address == 2'd3 ? writedata[HOLD_W-1:0] : hold_q;
    hw_pat_d = accept ? {SEG[res_digit], res_aux} : hw_pat_q;
    last_d   = accept ? res_digit : last_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = '0;
    phase_d  = phase_q;
    if (accept) begin
      state_d = HW;
      cnt_d   = hold_q;
      phase_d = 1'b0;
    end else if (state_q == HW) begin
      pre_d   = tick ? '0 : pre_q + 1'b1;
      phase_d = phase_q ^ tick;
      if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (!res_ready || (cnt_q == '0 && sw_wr) || (tick && cnt_q == HOLD_W'(1))) state_d = SW;
    end
    out_d = state_d == SW ? swdata_d : (blink_d & phase_d) ? 14'h3FFF : hw_pat_d;
  end
  // single state register bank, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= SW;
      swdata_q <= '0;
      hw_pat_q <= '0;
      out_q    <= '0;
      hw_en_q  <= 1'b0;
      lock_q   <= 1'b0;
      blink_q  <= 1'b0;
      phase_q  <= 1'b0;
      hold_q   <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      swdata_q <= swdata_d;
      hw_pat_q <= hw_pat_d;
      out_q    <= out_d;
      hw_en_q  <= hw_en_d;
      lock_q   <= lock_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      pre_q    <= pre_d;
    end
endmodule
